// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: select, sample and frame handshake signals between scan sequencer and mux/downstream
interface mux_scan_sequencer_if;
  logic       start;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  modport master (input start, mux_out, frame_ready, output s0, s1, frame, frame_valid, busy);
  modport slave (output start, mux_out, frame_ready, input s0, s1, frame, frame_valid, busy);
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps 4:1 mux selects, samples each channel after settling, offers a 4-bit frame
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit CONTINUOUS    = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_sequencer_if.master bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, HOLD = 2'd3;
  logic [1:0]    state, ch, sel;
  logic [CW-1:0] cnt;
  logic [3:0]    sbuf, frame_q;
  logic          fv, busy_q;
  assign {bus.s1, bus.s0} = sel;
  assign bus.frame        = frame_q;
  assign bus.frame_valid  = fv;
  assign bus.busy         = busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= 2'd0;
      cnt     <= '0;
      sel     <= 2'd0;
      sbuf    <= 4'd0;
      frame_q <= 4'd0;
      fv      <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state  <= SETTLE;
          ch     <= 2'd0;
          cnt    <= '0;
          sel    <= 2'd0;
          busy_q <= 1'b1;
        end
        SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          sbuf[ch] <= bus.mux_out;
          if (ch == 2'd3) begin
            state   <= HOLD;
            sel     <= 2'd0;
            frame_q <= {bus.mux_out, sbuf[2:0]};
            fv      <= 1'b1;
          end else begin
            ch    <= ch + 2'd1;
            sel   <= ch + 2'd1;
            state <= SETTLE;
          end
        end
        default: if (fv && bus.frame_ready) begin
          fv     <= 1'b0;
          ch     <= 2'd0;
          cnt    <= '0;
          state  <= CONTINUOUS ? SETTLE : IDLE;
          busy_q <= CONTINUOUS;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized scans against a timing/sampling model of the sequencer
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst0, rst1, glitch;
  logic [3:0] ch0, ch1;
  int checks = 0, failures = 0;
  mux_scan_sequencer_if b0();
  mux_scan_sequencer_if b1();
  mux_scan_sequencer #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b0)) d0 (.clk(clk), .rst(rst0), .bus(b0));
  mux_scan_sequencer #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b1)) d1 (.clk(clk), .rst(rst1), .bus(b1));
  always #5 clk = ~clk;
  // behavioural 4:1 muxes; b1's line can be corrupted while its select is still settling
  assign b0.mux_out = ch0[{b0.s1, b0.s0}];
  assign b1.mux_out = ch1[{b1.s1, b1.s0}] ^ glitch;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.start = 1'b1;
    repeat (2) tick;
    checks++;
    if ({b0.s1, b0.s0, b0.frame, b0.frame_valid, b0.busy} !== 8'd0) begin
      failures++;
      $display("FAIL reset: s=%b%b frame=%b fv=%b busy=%b, required all 0", b0.s1, b0.s0, b0.frame, b0.frame_valid, b0.busy);
    end
    checks++;
    if ({b1.s1, b1.s0, b1.frame, b1.frame_valid, b1.busy} !== 8'd0) begin
      failures++;
      $display("FAIL reset_cont: s=%b%b frame=%b fv=%b busy=%b, required all 0", b1.s1, b1.s0, b1.frame, b1.frame_valid, b1.busy);
    end
    rst0 = 1'b0;
    b0.start = 1'b0;
    tick;
    checks++;
    if (b0.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b, required 0", b0.busy);
    end
  endtask

  task automatic test_scan(input logic [3:0] v, input bit extra_starts, input int stall);
    logic [1:0] es;
    ch0 = v;
    b0.start = 1'b1;
    tick;
    for (int k = 1; k <= 12; k++) begin
      b0.start = extra_starts && (k == 3 || k == 7);
      tick;
      es = (k < 12) ? 2'(k / 3) : 2'd0;
      checks++;
      if ({b0.s1, b0.s0, b0.frame_valid, b0.busy} !== {es, k == 12, 1'b1}) begin
        failures++;
        $display("FAIL scan_step k=%0d: s=%b%b fv=%b busy=%b, required s=%b fv=%b busy=1", k, b0.s1, b0.s0, b0.frame_valid, b0.busy, es, k == 12);
      end
    end
    b0.start = 1'b0;
    checks++;
    if (b0.frame !== v) begin
      failures++;
      $display("FAIL scan_frame: frame=%b, required %b", b0.frame, v);
    end
    for (int i = 0; i < stall; i++) begin
      ch0 = ~v;
      tick;
      checks++;
      if ({b0.frame, b0.frame_valid, b0.busy, b0.s1, b0.s0} !== {v, 4'b1100}) begin
        failures++;
        $display("FAIL hold_stall %0d: frame=%b fv=%b busy=%b s=%b%b, required frame=%b fv=1 busy=1 s=00", i, b0.frame, b0.frame_valid, b0.busy, b0.s1, b0.s0, v);
      end
    end
    b0.frame_ready = 1'b1;
    b0.start = 1'b1;
    tick;
    b0.frame_ready = 1'b0;
    b0.start = 1'b0;
    checks++;
    if ({b0.frame, b0.frame_valid, b0.busy, b0.s1, b0.s0} !== {v, 4'b0000}) begin
      failures++;
      $display("FAIL handshake: frame=%b fv=%b busy=%b s=%b%b, required frame=%b fv=0 busy=0 s=00", b0.frame, b0.frame_valid, b0.busy, b0.s1, b0.s0, v);
    end
    if (extra_starts) begin
      for (int i = 0; i < 15; i++) begin
        tick;
        checks++;
        if ({b0.frame_valid, b0.busy} !== 2'b00) begin
          failures++;
          $display("FAIL single_frame %0d: fv=%b busy=%b, required 0 0", i, b0.frame_valid, b0.busy);
        end
      end
    end
  endtask

  task automatic test_rst_mid;
    ch0 = 4'($urandom);
    b0.start = 1'b1;
    tick;
    b0.start = 1'b0;
    repeat (4) tick;
    rst0 = 1'b1;
    b0.start = 1'b1;
    tick;
    rst0 = 1'b0;
    b0.start = 1'b0;
    checks++;
    if ({b0.s1, b0.s0, b0.frame, b0.frame_valid, b0.busy} !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid: s=%b%b frame=%b fv=%b busy=%b, required all 0", b0.s1, b0.s0, b0.frame, b0.frame_valid, b0.busy);
    end
    tick;
    checks++;
    if (b0.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle: busy=%b, required 0", b0.busy);
    end
    test_scan(4'b0110, 1'b0, 0);
  endtask

  task automatic test_continuous(input int nframes, input bit glitchy);
    logic [3:0] cur;
    cur = ch1;
    glitch = glitchy;
    for (int f = 0; f < nframes; f++) begin
      for (int p = 1; p <= 9; p++) begin
        tick;
        glitch = glitchy && ((p % 9) % 2 == 0) && p != 8;
        checks++;
        if (p == 8) begin
          if ({b1.frame_valid, b1.busy, b1.frame} !== {2'b11, cur}) begin
            failures++;
            $display("FAIL cont_frame f=%0d g=%0d: fv=%b busy=%b frame=%b, required fv=1 busy=1 frame=%b", f, glitchy, b1.frame_valid, b1.busy, b1.frame, cur);
          end
          cur = 4'($urandom);
          ch1 = cur;
        end else if ({b1.frame_valid, b1.busy} !== 2'b01) begin
          failures++;
          $display("FAIL cont_gap f=%0d p=%0d: fv=%b busy=%b, required fv=0 busy=1", f, p, b1.frame_valid, b1.busy);
        end
      end
    end
    glitch = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    glitch = 1'b0;
    ch0 = 4'd0;
    ch1 = 4'($urandom);
    b0.start = 1'b0;
    b0.frame_ready = 1'b0;
    b1.start = 1'b0;
    b1.frame_ready = 1'b1;
    test_reset;
    test_scan(4'b1101, 1'b0, 5);
    test_scan(4'($urandom), 1'b1, 0);
    test_scan(4'($urandom), 1'b0, 2);
    test_rst_mid;
    rst1 = 1'b0;
    tick;
    b1.start = 1'b1;
    tick;
    b1.start = 1'b0;
    test_continuous(4, 1'b0);
    test_continuous(3, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
